// File: rtl/mor1kx_irq_ctrl.sv
// mor1kx_irq_ctrl: PIC (PICMR/PICSR) plus tick timer merge,
// issuing one prioritised exception request held until acknowledged.
module mor1kx_irq_ctrl #(
    parameter string OPTION_PIC_TRIGGER   = "LEVEL",
    parameter int    OPTION_PIC_NMI_WIDTH = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] spr_ttmr_i,
    input  logic [31:0] irq_i,
    input  logic        sr_tee_i,
    input  logic        sr_iee_i,
    input  logic        except_ack_i,
    output logic        except_valid_o,
    output logic        except_tt_o,
    output logic        except_pic_o,
    output logic [31:0] spr_picmr_o,
    output logic [31:0] spr_picsr_o,
    input  logic        spr_access_i,
    input  logic        spr_we_i,
    input  logic [15:0] spr_addr_i,
    input  logic [31:0] spr_dat_i,
    output logic        spr_bus_ack,
    output logic [31:0] spr_dat_o
);

    localparam bit EDGE = (OPTION_PIC_TRIGGER == "EDGE");
    localparam logic [31:0] NMI_MASK = (OPTION_PIC_NMI_WIDTH == 0) ? 32'd0 :
        (32'hffff_ffff >> (32 - OPTION_PIC_NMI_WIDTH));

    typedef enum logic [1:0] {IDLE, REQ, BLOCK} state_t;

    state_t      state;
    logic        cause_tt;
    logic [31:0] picmr;
    logic [31:0] picsr;
    logic [31:0] picsr_d;
    logic [31:0] irq_q;
    logic        sel_mr;
    logic        sel_sr;
    logic        picmr_we;
    logic        picsr_we;
    logic        tt_pend;
    logic        pic_pend;
    logic        unused_ttmr;

    assign unused_ttmr = ^{spr_ttmr_i[31:30], spr_ttmr_i[27:0]};

    assign sel_mr   = (spr_addr_i == 16'h4800);
    assign sel_sr   = (spr_addr_i == 16'h4802);
    assign picmr_we = spr_access_i & spr_we_i & sel_mr;
    assign picsr_we = spr_access_i & spr_we_i & sel_sr;

    assign spr_bus_ack = spr_access_i;
    assign spr_picmr_o = picmr;
    assign spr_picsr_o = picsr;

    always_comb begin
        spr_dat_o = 32'd0;
        unique case (1'b1)
            sel_mr:  spr_dat_o = picmr;
            sel_sr:  spr_dat_o = picsr;
            default: spr_dat_o = 32'd0;
        endcase
    end

    // Edge mode: a fresh edge beats a W1C on the same bit.
    always_comb begin
        if (EDGE)
            picsr_d = (picsr & ~(picsr_we ? spr_dat_i : 32'd0)) |
                      (irq_i & ~irq_q & picmr);
        else
            picsr_d = irq_i & picmr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            picmr <= NMI_MASK;
            picsr <= 32'd0;
            irq_q <= 32'd0;
        end else begin
            if (picmr_we)
                picmr <= spr_dat_i | NMI_MASK;
            picsr <= picsr_d;
            irq_q <= irq_i;
        end
    end

    assign tt_pend  = spr_ttmr_i[29] & spr_ttmr_i[28] & sr_tee_i;
    assign pic_pend = (|picsr) & sr_iee_i;

    // BLOCK holds off re-issue until the pipeline has cleared SR.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cause_tt       <= 1'b0;
            except_valid_o <= 1'b0;
            except_tt_o    <= 1'b0;
            except_pic_o   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (tt_pend | pic_pend) begin
                        state          <= REQ;
                        cause_tt       <= tt_pend;
                        except_valid_o <= 1'b1;
                        except_tt_o    <= tt_pend;
                        except_pic_o   <= ~tt_pend;
                    end
                end
                REQ: begin
                    if (except_ack_i) begin
                        state          <= BLOCK;
                        except_valid_o <= 1'b0;
                        except_tt_o    <= 1'b0;
                        except_pic_o   <= 1'b0;
                    end
                end
                BLOCK: begin
                    if (cause_tt ? ~tt_pend : ~pic_pend)
                        state <= IDLE;
                end
                default: begin
                    state          <= IDLE;
                    except_valid_o <= 1'b0;
                    except_tt_o    <= 1'b0;
                    except_pic_o   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mor1kx_irq_ctrl.sv
// Bench for mor1kx_irq_ctrl: LEVEL and EDGE instances (NMI=2) checked
// every cycle against a behavioural model, plus directed literal checks.
module tb_mor1kx_irq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ttmr = 32'd0;
    logic [31:0] irq = 32'd0;
    logic        tee = 1'b0;
    logic        iee = 1'b0;
    logic        ack = 1'b0;
    logic        acc = 1'b0;
    logic        we = 1'b0;
    logic [15:0] addr = 16'd0;
    logic [31:0] dat = 32'd0;

    logic        v [2];
    logic        t [2];
    logic        p [2];
    logic [31:0] mr [2];
    logic [31:0] sr [2];
    logic        bak [2];
    logic [31:0] rd [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mor1kx_irq_ctrl #(
        .OPTION_PIC_TRIGGER("LEVEL"),
        .OPTION_PIC_NMI_WIDTH(2)
    ) u_lvl (
        .clk(clk), .rst(rst), .spr_ttmr_i(ttmr), .irq_i(irq),
        .sr_tee_i(tee), .sr_iee_i(iee), .except_ack_i(ack),
        .except_valid_o(v[0]), .except_tt_o(t[0]), .except_pic_o(p[0]),
        .spr_picmr_o(mr[0]), .spr_picsr_o(sr[0]),
        .spr_access_i(acc), .spr_we_i(we), .spr_addr_i(addr),
        .spr_dat_i(dat), .spr_bus_ack(bak[0]), .spr_dat_o(rd[0])
    );

    mor1kx_irq_ctrl #(
        .OPTION_PIC_TRIGGER("EDGE"),
        .OPTION_PIC_NMI_WIDTH(2)
    ) u_edg (
        .clk(clk), .rst(rst), .spr_ttmr_i(ttmr), .irq_i(irq),
        .sr_tee_i(tee), .sr_iee_i(iee), .except_ack_i(ack),
        .except_valid_o(v[1]), .except_tt_o(t[1]), .except_pic_o(p[1]),
        .spr_picmr_o(mr[1]), .spr_picsr_o(sr[1]),
        .spr_access_i(acc), .spr_we_i(we), .spr_addr_i(addr),
        .spr_dat_i(dat), .spr_bus_ack(bak[1]), .spr_dat_o(rd[1])
    );

    // Model: request phase 0 = free, 1 = requesting, 2 = waiting for SR clear
    logic [31:0] m_mr [2];
    logic [31:0] m_sr [2];
    int          m_ph [2];
    bit          m_ctt [2];
    logic [31:0] m_prev;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic model_step();
        bit          tp;
        bit          pp;
        logic [31:0] nsr;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_mr[i]  = 32'h3;
                m_sr[i]  = 32'd0;
                m_ph[i]  = 0;
                m_ctt[i] = 1'b0;
            end else begin
                tp = ttmr[29] && ttmr[28] && tee;
                pp = (m_sr[i] != 0) && iee;
                if (m_ph[i] == 0) begin
                    if (tp || pp) begin
                        m_ph[i]  = 1;
                        m_ctt[i] = tp;
                    end
                end else if (m_ph[i] == 1) begin
                    if (ack) m_ph[i] = 2;
                end else begin
                    if (m_ctt[i] ? !tp : !pp) m_ph[i] = 0;
                end
                if (i == 0)
                    nsr = irq & m_mr[i];
                else
                    nsr = (m_sr[i] & ~((acc && we && addr == 16'h4802) ? dat : 32'd0))
                          | (irq & ~m_prev & m_mr[i]);
                if (acc && we && addr == 16'h4800)
                    m_mr[i] = dat | 32'h3;
                m_sr[i] = nsr;
            end
        end
        m_prev = rst ? 32'd0 : irq;
    endtask

    task automatic compare_all();
        logic [31:0] erd;
        bit          ev;
        for (int i = 0; i < 2; i++) begin
            ev = (m_ph[i] == 1);
            erd = (addr == 16'h4800) ? m_mr[i] :
                  (addr == 16'h4802) ? m_sr[i] : 32'd0;
            chk($sformatf("valid%0d", i), {31'd0, v[i]}, {31'd0, ev});
            chk($sformatf("tt%0d", i), {31'd0, t[i]}, {31'd0, ev && m_ctt[i]});
            chk($sformatf("pic%0d", i), {31'd0, p[i]}, {31'd0, ev && !m_ctt[i]});
            chk($sformatf("picmr%0d", i), mr[i], m_mr[i]);
            chk($sformatf("picsr%0d", i), sr[i], m_sr[i]);
            chk($sformatf("busack%0d", i), {31'd0, bak[i]}, {31'd0, acc});
            chk($sformatf("rdata%0d", i), rd[i], erd);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic spr_wr(logic [15:0] a, logic [31:0] d);
        acc = 1'b1; we = 1'b1; addr = a; dat = d;
        cyc();
        acc = 1'b0; we = 1'b0; addr = 16'd0; dat = 32'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_mr[i] = 32'h3; m_sr[i] = 32'd0; m_ph[i] = 0; m_ctt[i] = 1'b0;
        end
        m_prev = 32'd0;
        @(negedge clk);

        // reset and PICMR readback
        do_reset();
        chk("rst_valid", {31'd0, v[0]}, 32'd0);
        chk("rst_picsr", sr[1], 32'd0);
        acc = 1'b1; addr = 16'h4800;
        #1;
        chk("rd_picmr_rst", rd[0], 32'h0000_0003);
        chk("rd_ack", {31'd0, bak[0]}, 32'd1);
        cyc();
        acc = 1'b0; addr = 16'd0;

        // level mode latency, ack, block
        spr_wr(16'h4800, 32'h10);
        iee = 1'b1; irq = 32'h10;
        cyc();
        chk("lvl_picsr_c1", sr[0], 32'h10);
        chk("lvl_valid_c1", {31'd0, v[0]}, 32'd0);
        cyc();
        chk("lvl_valid_c2", {31'd0, v[0]}, 32'd1);
        chk("lvl_pic_c2", {31'd0, p[0]}, 32'd1);
        cyc();
        cyc();
        ack = 1'b1;
        cyc();
        ack = 1'b0;
        chk("lvl_valid_c5", {31'd0, v[0]}, 32'd0);
        repeat (3) cyc();
        chk("lvl_block", {31'd0, v[0]}, 32'd0);
        iee = 1'b0; irq = 32'd0;
        repeat (2) cyc();

        // tt priority and cause hold
        do_reset();
        spr_wr(16'h4800, 32'h10);
        irq = 32'h10; iee = 1'b1; tee = 1'b1; ttmr = 32'h3000_0000;
        cyc();
        chk("pri_valid", {31'd0, v[0]}, 32'd1);
        chk("pri_tt", {31'd0, t[0]}, 32'd1);
        chk("pri_pic", {31'd0, p[0]}, 32'd0);
        tee = 1'b0; ttmr = 32'h2000_0000;
        repeat (2) cyc();
        chk("hold_valid", {31'd0, v[0]}, 32'd1);
        chk("hold_tt", {31'd0, t[0]}, 32'd1);
        ack = 1'b1;
        cyc();
        ack = 1'b0;
        chk("pri_ack", {31'd0, v[0]}, 32'd0);
        cyc();
        cyc();
        chk("pic_after_valid", {31'd0, v[0]}, 32'd1);
        chk("pic_after_pic", {31'd0, p[0]}, 32'd1);
        ack = 1'b1;
        cyc();
        ack = 1'b0; irq = 32'd0; iee = 1'b0; ttmr = 32'd0;
        repeat (2) cyc();

        // edge capture, W1C, set beats clear
        do_reset();
        spr_wr(16'h4800, 32'h80);
        irq = 32'h80;
        cyc();
        irq = 32'd0;
        cyc();
        chk("edg_set", sr[1], 32'h80);
        cyc();
        chk("edg_held", sr[1], 32'h80);
        spr_wr(16'h4802, 32'h80);
        chk("edg_w1c", sr[1], 32'h0);
        irq = 32'h80;
        cyc();
        irq = 32'd0;
        cyc();
        irq = 32'h80;
        spr_wr(16'h4802, 32'h80);
        chk("edg_set_wins", sr[1], 32'h80);
        irq = 32'd0;
        cyc();

        // reset while requesting
        do_reset();
        tee = 1'b1; ttmr = 32'h3000_0000;
        spr_wr(16'h4800, 32'h55);
        chk("rq_valid", {31'd0, v[0]}, 32'd1);
        chk("rq_picmr", mr[0], 32'h57);
        rst = 1'b1;
        cyc();
        rst = 1'b0; tee = 1'b0; ttmr = 32'd0;
        chk("rstreq_valid", {31'd0, v[0]}, 32'd0);
        chk("rstreq_picsr", sr[1], 32'd0);
        chk("rstreq_picmr", mr[1], 32'h3);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom % 200) == 0;
            if ($urandom % 3 == 0) irq = $urandom & $urandom & $urandom;
            ttmr = $urandom;
            ttmr[29] = ($urandom % 4) != 0;
            ttmr[28] = ($urandom % 3) == 0;
            tee = ($urandom % 5) != 0;
            iee = ($urandom % 4) != 0;
            ack = ($urandom % 3) == 0;
            acc = ($urandom % 3) == 0;
            we = $urandom % 2;
            case ($urandom % 3)
                0: addr = 16'h4800;
                1: addr = 16'h4802;
                default: addr = 16'($urandom);
            endcase
            dat = $urandom;
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
